// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter states, word type,
// and the grant-selection helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t GRANT_I = 2'd1;
  localparam arb_state_t GRANT_D = 2'd2;

  // Data wins unless a pending fetch has waited out a full data streak.
  function automatic arb_state_t arbitrate(input logic i_req, input logic d_req,
                                           input logic fetch_due);
    arb_state_t grant;
    if (d_req && !(i_req && fetch_due)) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end else begin
      grant = IDLE;
    end
    return grant;
  endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data completions made while a fetch waits.
// Exposes the next-cycle value so arbitration can react in the completion cycle.
module arb_streak_ctr #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned CNT_W        = $clog2(MAX_D_STREAK + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] streak_nxt
);

  logic [CNT_W-1:0] streak_q;

  always_comb begin
    streak_nxt = streak_q;
    if (clr) begin
      streak_nxt = '0;
    end else if (inc && (streak_q != CNT_W'(MAX_D_STREAK))) begin
      streak_nxt = streak_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_nxt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access, data first
// with a bounded streak. Define ARB_STATS_EN to add grant and fetch-stall counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef ARB_STATS_EN
  ,
  output word_t             i_grants,
  output word_t             d_grants,
  output word_t             i_stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_D_STREAK + 1);

  arb_state_t       state_q, state_d, next_grant;
  logic             d_req, ram_access, i_done, d_done, fetch_due;
  logic [CNT_W-1:0] streak_nxt;

  assign d_req      = dREN | dWEN;
  assign ram_access = (ramstate_t'(ramstate) == ACCESS);
  assign i_done     = !RST && (state_q == GRANT_I) && iREN && ram_access;
  assign d_done     = !RST && (state_q == GRANT_D) && d_req && ram_access;

  arb_streak_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .CNT_W        (CNT_W)
  ) u_streak (
    .CLK        (CLK),
    .RST        (RST),
    .inc        (d_done),
    .clr        (i_done | ~iREN),
    .streak_nxt (streak_nxt)
  );

  // Uses the post-update streak so the grant after the last allowed data access
  // already goes to fetch, with no bubble.
  assign fetch_due  = (streak_nxt == CNT_W'(MAX_D_STREAK));
  assign next_grant = arbitrate(iREN, d_req, fetch_due);

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = d_req;
    iload    = ramload;
    dload    = ramload;
    if (!RST) begin
      case (state_q)
        IDLE: state_d = next_grant;
        GRANT_I: begin
          if (!iREN) begin
            state_d = next_grant;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (i_done) begin
              iwait   = 1'b0;
              state_d = next_grant;
            end
          end
        end
        GRANT_D: begin
          if (!d_req) begin
            state_d = next_grant;
          end else begin
            ramWEN   = dWEN;
            ramREN   = ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (d_done) begin
              dwait   = 1'b0;
              state_d = next_grant;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_grants       <= '0;
      d_grants       <= '0;
      i_stall_cycles <= '0;
    end else begin
      if (i_done) i_grants <= i_grants + 1'b1;
      if (d_done) d_grants <= d_grants + 1'b1;
      if (iREN && iwait) i_stall_cycles <= i_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus hand-written
// reset sequences. Stats counters are checked when ARB_STATS_EN is defined.
module tb_mem_arbiter;

  localparam logic [31:0] IADDR  = 32'h0000_0040;
  localparam logic [31:0] DADDR  = 32'h0000_0080;
  localparam logic [31:0] DSTORE = 32'hDEAD_BEEF;
  localparam logic [31:0] RLOAD  = 32'h2108_000A;
  localparam logic [1:0]  F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

  logic        CLK, RST;
  logic        iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
`ifdef ARB_STATS_EN
  logic [31:0] i_grants, d_grants, i_stall_cycles;
`endif

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef ARB_STATS_EN
    ,
    .i_grants       (i_grants),
    .d_grants       (d_grants),
    .i_stall_cycles (i_stall_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw;
    logic [1:0]  rs;
    logic        x_ren, x_wen, x_iwait, x_dwait;
    logic [31:0] x_addr, x_store;
  } vec_t;

  vec_t tbl[22];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // ir dr dw rs | ramREN ramWEN iwait dwait ramaddr ramstore
    tbl[0]  = '{1, 0, 0, F, 0, 0, 1, 0, 0, 0};            // idle, fetch arbitrated
    tbl[1]  = '{1, 0, 0, B, 1, 0, 1, 0, IADDR, 0};
    tbl[2]  = '{1, 0, 0, B, 1, 0, 1, 0, IADDR, 0};
    tbl[3]  = '{1, 0, 0, A, 1, 0, 0, 0, IADDR, 0};        // fetch completes
    tbl[4]  = '{0, 0, 0, F, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, F, 0, 0, 1, 1, 0, 0};            // simultaneous requests
    tbl[6]  = '{1, 1, 0, B, 1, 0, 1, 1, DADDR, DSTORE};   // data first
    tbl[7]  = '{1, 1, 0, A, 1, 0, 1, 0, DADDR, DSTORE};   // data completion 1
    tbl[8]  = '{1, 1, 0, A, 1, 0, 1, 0, DADDR, DSTORE};   // 2
    tbl[9]  = '{1, 1, 0, A, 1, 0, 1, 0, DADDR, DSTORE};   // 3
    tbl[10] = '{1, 1, 0, A, 1, 0, 1, 0, DADDR, DSTORE};   // 4
    tbl[11] = '{1, 1, 0, A, 1, 0, 0, 1, IADDR, 0};        // forced fetch, no bubble
    tbl[12] = '{1, 1, 0, A, 1, 0, 1, 0, DADDR, DSTORE};   // data resumes
    tbl[13] = '{0, 0, 1, B, 0, 1, 0, 1, DADDR, DSTORE};   // write
    tbl[14] = '{0, 1, 1, B, 0, 1, 0, 1, DADDR, DSTORE};   // write beats read
    tbl[15] = '{0, 0, 1, E, 0, 1, 0, 1, DADDR, DSTORE};   // ERROR holds like BUSY
    tbl[16] = '{0, 0, 1, A, 0, 1, 0, 0, DADDR, DSTORE};   // write completes
    tbl[17] = '{1, 1, 0, B, 1, 0, 1, 1, DADDR, DSTORE};
    tbl[18] = '{1, 0, 0, B, 0, 0, 1, 0, 0, 0};            // data withdrawn
    tbl[19] = '{1, 0, 0, F, 1, 0, 1, 0, IADDR, 0};        // pending fetch granted
    tbl[20] = '{0, 0, 0, F, 0, 0, 0, 0, 0, 0};
    tbl[21] = '{0, 0, 0, F, 0, 0, 0, 0, 0, 0};

    iaddr = IADDR; daddr = DADDR; dstore = DSTORE; ramload = RLOAD;
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramstate = F;

    // Reset state: enables low, wait follows request.
    @(negedge CLK);
    check("reset ramREN", 32'(ramREN), 0);
    check("reset ramWEN", 32'(ramWEN), 0);
    check("reset ramaddr", ramaddr, 0);
    check("reset iwait", 32'(iwait), 1);
    check("reset dwait", 32'(dwait), 0);
    dREN = 1'b1; #1;
    check("reset dwait tracks dREN", 32'(dwait), 1);
    @(negedge CLK);
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(posedge CLK); #1;
      iREN = tbl[i].ir; dREN = tbl[i].dr; dWEN = tbl[i].dw; ramstate = tbl[i].rs;
      @(negedge CLK);
      check($sformatf("v%0d ramREN", i), 32'(ramREN), 32'(tbl[i].x_ren));
      check($sformatf("v%0d ramWEN", i), 32'(ramWEN), 32'(tbl[i].x_wen));
      check($sformatf("v%0d iwait", i), 32'(iwait), 32'(tbl[i].x_iwait));
      check($sformatf("v%0d dwait", i), 32'(dwait), 32'(tbl[i].x_dwait));
      check($sformatf("v%0d ramaddr", i), ramaddr, tbl[i].x_addr);
      check($sformatf("v%0d ramstore", i), ramstore, tbl[i].x_store);
      if (tbl[i].ir && !tbl[i].x_iwait) check($sformatf("v%0d iload", i), iload, RLOAD);
      if ((tbl[i].dr || tbl[i].dw) && !tbl[i].x_dwait)
        check($sformatf("v%0d dload", i), dload, RLOAD);
    end

`ifdef ARB_STATS_EN
    check("stats i_grants", i_grants, 2);
    check("stats d_grants", d_grants, 6);
    check("stats i_stall_cycles", i_stall_cycles, 13);
`endif

    // Reset in the middle of a write that the RAM holds BUSY.
    @(posedge CLK); #1;
    dWEN = 1'b1; ramstate = B;
    @(negedge CLK);
    check("rst seq idle ramWEN", 32'(ramWEN), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst seq granted ramWEN", 32'(ramWEN), 1);
    RST = 1'b1; #1;
    check("rst mid-access ramWEN", 32'(ramWEN), 0);
    check("rst mid-access dwait", 32'(dwait), 1);
    check("rst mid-access ramaddr", ramaddr, 0);
    check("rst mid-access ramstore", ramstore, 0);
`ifdef ARB_STATS_EN
    check("rst stats d_grants", d_grants, 0);
    check("rst stats i_stall_cycles", i_stall_cycles, 0);
`endif
    @(posedge CLK); #1;
    @(negedge CLK);
    check("in reset ramWEN", 32'(ramWEN), 0);
    RST = 1'b0; #1;
    check("after release ramWEN", 32'(ramWEN), 0);
    check("after release dwait", 32'(dwait), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("re-grant ramWEN", 32'(ramWEN), 1);
    check("re-grant ramaddr", ramaddr, DADDR);
    ramstate = A; #1;
    check("re-grant completes dwait", 32'(dwait), 0);
    @(posedge CLK); #1;
    dWEN = 1'b0; ramstate = F;
    @(negedge CLK);
    check("final ramWEN", 32'(ramWEN), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
